// File: rtl/lnvd_channel_aligner_if.sv
// Bus bundle for lnvd_channel_aligner: frame strobe, four sample lanes, per-channel delays
// and the aligned output lanes.
interface lnvd_channel_aligner_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 6
);
  logic              sample_valid;
  logic [DATA_W-1:0] data_in1;
  logic [DATA_W-1:0] data_in2;
  logic [DATA_W-1:0] data_in3;
  logic [DATA_W-1:0] data_in4;
  logic [ADDR_W-1:0] delay1;
  logic [ADDR_W-1:0] delay2;
  logic [ADDR_W-1:0] delay3;
  logic [ADDR_W-1:0] delay4;
  logic              delay_load;
  logic [DATA_W-1:0] data_out1;
  logic [DATA_W-1:0] data_out2;
  logic [DATA_W-1:0] data_out3;
  logic [DATA_W-1:0] data_out4;
  logic              out_valid;
  logic              primed;

  modport master (
    output sample_valid, data_in1, data_in2, data_in3, data_in4,
    output delay1, delay2, delay3, delay4, delay_load,
    input  data_out1, data_out2, data_out3, data_out4, out_valid, primed
  );

  modport slave (
    input  sample_valid, data_in1, data_in2, data_in3, data_in4,
    input  delay1, delay2, delay3, delay4, delay_load,
    output data_out1, data_out2, data_out3, data_out4, out_valid, primed
  );
endinterface

// File: rtl/lnvd_channel_aligner.sv
// Four-channel skew remover: shared circular buffer, one write pointer, per-channel delays.
// Optional LNVD_ALIGN_ZERO_FILL_EN: emit every frame in FILL, zeroing not-yet-valid channels.
module lnvd_channel_aligner #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  lnvd_channel_aligner_if.slave bus
);
  localparam int unsigned NumCh = 4;

  typedef enum logic {StFill, StRun} state_e;

  logic [DATA_W-1:0]       din     [NumCh];
  logic [ADDR_W-1:0]       dreq    [NumCh];
  logic [NumCh*DATA_W-1:0] mem_q   [DEPTH];
  logic [ADDR_W-1:0]       rd_addr [NumCh];
  logic [NumCh*DATA_W-1:0] rd_word [NumCh];
  logic [DATA_W-1:0]       samp    [NumCh];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [ADDR_W-1:0] delay_q [NumCh];
  logic [ADDR_W-1:0] delay_d [NumCh];
  logic [DATA_W-1:0] dout_q  [NumCh];
  logic [DATA_W-1:0] dout_d  [NumCh];
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] max_old, max_new;
  logic              go_run;

  assign din[0]  = bus.data_in1;
  assign din[1]  = bus.data_in2;
  assign din[2]  = bus.data_in3;
  assign din[3]  = bus.data_in4;
  assign dreq[0] = bus.delay1;
  assign dreq[1] = bus.delay2;
  assign dreq[2] = bus.delay3;
  assign dreq[3] = bus.delay4;

  always_comb begin
    max_old = '0;
    max_new = '0;
    for (int unsigned k = 0; k < NumCh; k++) begin
      if (delay_q[k] > max_old) max_old = delay_q[k];
      if (dreq[k] > max_new)    max_new = dreq[k];
    end
  end

  // Reads see the pre-write contents; delay 0 bypasses straight from the input lane.
  always_comb begin
    for (int unsigned k = 0; k < NumCh; k++) begin
      rd_addr[k] = wr_ptr_q - delay_q[k];
      rd_word[k] = mem_q[rd_addr[k]];
      samp[k]    = (delay_q[k] == '0) ? din[k] : rd_word[k][k*DATA_W +: DATA_W];
`ifdef LNVD_ALIGN_ZERO_FILL_EN
      if (delay_q[k] > fill_cnt_q) samp[k] = '0;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    delay_d     = delay_q;
    dout_d      = dout_q;
    out_valid_d = 1'b0;
    go_run      = (state_q == StRun) || (fill_cnt_q >= max_old);
    if (bus.sample_valid) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (fill_cnt_q != ADDR_W'(DEPTH - 1)) fill_cnt_d = fill_cnt_q + 1'b1;
      state_d = go_run ? StRun : StFill;
`ifdef LNVD_ALIGN_ZERO_FILL_EN
      out_valid_d = 1'b1;
      dout_d      = samp;
`else
      if (go_run) begin
        out_valid_d = 1'b1;
        dout_d      = samp;
      end
`endif
    end
    // A coincident frame already used the old delays; judge the new ones on the updated fill.
    if (bus.delay_load) begin
      delay_d = dreq;
      if (max_new > fill_cnt_d) state_d = StFill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned k = 0; k < NumCh; k++) begin
        delay_q[k] <= '0;
        dout_q[k]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      out_valid_q <= out_valid_d;
      delay_q     <= delay_d;
      dout_q      <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.sample_valid) mem_q[wr_ptr_q] <= {din[3], din[2], din[1], din[0]};
  end

  assign bus.data_out1 = dout_q[0];
  assign bus.data_out2 = dout_q[1];
  assign bus.data_out3 = dout_q[2];
  assign bus.data_out4 = dout_q[3];
  assign bus.out_valid = out_valid_q;
  assign bus.primed    = (state_q == StRun);
endmodule

// File: tb/tb_lnvd_channel_aligner.sv
// Scoreboard bench for lnvd_channel_aligner: stimulus pushes expected frames, a negedge
// monitor pops and compares them whenever out_valid is seen.
module tb_lnvd_channel_aligner;
  typedef logic [3:0][11:0] vec_t;
  typedef logic [3:0][5:0]  dly_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t exp_q[$];

  lnvd_channel_aligner_if #(.DATA_W(12), .ADDR_W(6)) bus ();

  lnvd_channel_aligner #(.DATA_W(12), .DEPTH(64), .ADDR_W(6)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        check("data_out1", 32'(bus.data_out1), 32'(e[0]));
        check("data_out2", 32'(bus.data_out2), 32'(e[1]));
        check("data_out3", 32'(bus.data_out3), 32'(e[2]));
        check("data_out4", 32'(bus.data_out4), 32'(e[3]));
      end
    end
  end

  function automatic vec_t ramp(input vec_t base, input int n);
    vec_t r;
    for (int c = 0; c < 4; c++) r[c] = base[c] + 12'(n);
    return r;
  endfunction

  task automatic cycle(input bit sv, input bit ld, input vec_t din, input dly_t dly,
                       input bit ev, input vec_t ex);
    bus.sample_valid = sv;
    bus.delay_load   = ld;
    bus.data_in1 = din[0];
    bus.data_in2 = din[1];
    bus.data_in3 = din[2];
    bus.data_in4 = din[3];
    bus.delay1 = dly[0];
    bus.delay2 = dly[1];
    bus.delay3 = dly[2];
    bus.delay4 = dly[3];
    if (ev) exp_q.push_back(ex);
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    bus.delay_load   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_primed", 32'(bus.primed), 32'd0);
    check("rst_data_out1", 32'(bus.data_out1), 32'd0);
    check("rst_data_out4", 32'(bus.data_out4), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    repeat (2) @(posedge clk);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t base;
    vec_t ex;
    vec_t din;
    dly_t dly;
    bus.sample_valid = 1'b0;
    bus.delay_load   = 1'b0;
    bus.data_in1 = '0; bus.data_in2 = '0; bus.data_in3 = '0; bus.data_in4 = '0;
    bus.delay1 = '0; bus.delay2 = '0; bus.delay3 = '0; bus.delay4 = '0;

    // Zero delays: every frame comes straight through one clock later.
    do_reset();
    dly = '0;
    for (int n = 0; n < 3; n++) begin
      din = {12'h400 + 12'(n), 12'h300 + 12'(n), 12'h200 + 12'(n), 12'h001 + 12'(n)};
      cycle(1'b1, 1'b0, din, dly, 1'b1, din);
      if (n == 0) check("p1_primed_after_first", 32'(bus.primed), 32'd1);
    end
    drain("p1_pending");

`ifndef LNVD_ALIGN_ZERO_FILL_EN
    // delay1=3: nothing for frames 0-2, then ch1 trails ch2 by three frames.
    do_reset();
    dly = '0;
    dly[0] = 6'd3;
    cycle(1'b0, 1'b1, '0, dly, 1'b0, '0);
    base = {12'h010, 12'h010, 12'h010, 12'h010};
    for (int n = 0; n < 10; n++) begin
      ex = ramp(base, n);
      ex[0] = 12'h010 + 12'(n) - 12'd3;
      cycle(1'b1, 1'b0, ramp(base, n), dly, n >= 3, ex);
      if (n == 2) begin
        check("p2_primed_during_fill", 32'(bus.primed), 32'd0);
        check("p2_hold_during_fill", 32'(bus.data_out1), 32'd0);
      end
      if (n == 3) check("p2_primed_at_frame3", 32'(bus.primed), 32'd1);
    end
    drain("p2_pending");

    // Maximum delay on ch4 over 200 frames, crossing several pointer wraps.
    do_reset();
    dly = '0;
    dly[3] = 6'd63;
    cycle(1'b0, 1'b1, '0, dly, 1'b0, '0);
    base = {12'h800, 12'h400, 12'h200, 12'h000};
    for (int n = 0; n < 200; n++) begin
      ex = ramp(base, n);
      ex[3] = 12'h800 + 12'(n) - 12'd63;
      cycle(1'b1, 1'b0, ramp(base, n), dly, n >= 63, ex);
      if (n == 62) check("p3_primed_frame62", 32'(bus.primed), 32'd0);
      if (n == 63) check("p3_primed_frame63", 32'(bus.primed), 32'd1);
    end
    drain("p3_pending");

    // Raise delay2 to 40 in RUN at fill_cnt=10, coincident with a frame.
    do_reset();
    dly = '0;
    base = {12'h900, 12'h700, 12'h500, 12'h300};
    for (int n = 0; n < 10; n++) cycle(1'b1, 1'b0, ramp(base, n), dly, 1'b1, ramp(base, n));
    dly[1] = 6'd40;
    cycle(1'b1, 1'b1, ramp(base, 10), dly, 1'b1, ramp(base, 10));
    check("p4_primed_drops", 32'(bus.primed), 32'd0);
    for (int n = 11; n < 46; n++) begin
      ex = ramp(base, n);
      ex[1] = 12'h500 + 12'(n) - 12'd40;
      cycle(1'b1, 1'b0, ramp(base, n), dly, n >= 40, ex);
      if (n == 39) check("p4_primed_frame39", 32'(bus.primed), 32'd0);
      if (n == 40) check("p4_primed_frame40", 32'(bus.primed), 32'd1);
    end
    drain("p4_pending");

    // Asynchronous reset mid-stream, then frames resume with zero delays.
    do_reset();
    dly = '0;
    dly[0] = 6'd2;
    cycle(1'b0, 1'b1, '0, dly, 1'b0, '0);
    base = {12'h0c0, 12'h0b0, 12'h0a0, 12'h090};
    for (int n = 0; n < 5; n++) begin
      ex = ramp(base, n);
      ex[0] = 12'h090 + 12'(n) - 12'd2;
      cycle(1'b1, 1'b0, ramp(base, n), dly, n >= 2, ex);
    end
    #6;
    rst_n = 1'b0;
    #1;
    check("p5_async_out_valid", 32'(bus.out_valid), 32'd0);
    check("p5_async_primed", 32'(bus.primed), 32'd0);
    check("p5_async_data_out1", 32'(bus.data_out1), 32'd0);
    check("p5_async_data_out3", 32'(bus.data_out3), 32'd0);
    cycle(1'b1, 1'b0, {12'hfff, 12'hfff, 12'hfff, 12'hfff}, dly, 1'b0, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    din = {12'h444, 12'h333, 12'h222, 12'habc};
    cycle(1'b1, 1'b0, din, dly, 1'b1, din);
    check("p5_primed_after_release", 32'(bus.primed), 32'd1);
    drain("p5_pending");
`else
    // Zero-fill: delay3=5 emits from frame 0 with ch3 forced to 0 until frame 5.
    do_reset();
    dly = '0;
    dly[2] = 6'd5;
    cycle(1'b0, 1'b1, '0, dly, 1'b0, '0);
    base = {12'h600, 12'h500, 12'h400, 12'h300};
    for (int n = 0; n < 9; n++) begin
      ex = ramp(base, n);
      ex[2] = (n < 5) ? 12'h000 : 12'h500 + 12'(n) - 12'd5;
      cycle(1'b1, 1'b0, ramp(base, n), dly, 1'b1, ex);
      if (n == 4) check("zf_primed_frame4", 32'(bus.primed), 32'd0);
      if (n == 5) check("zf_primed_frame5", 32'(bus.primed), 32'd1);
    end
    drain("zf_pending");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lnvd_channel_aligner.md
Name: lnvd_channel_aligner

Overview:
- Receive-side counterpart to the LNVD wire-delay stage: it removes inter-channel skew rather than adding propagation delay.
- Takes 4 × 12-bit microphone/ADC sample frames at the 250 kHz frame rate and delays each channel by its own programmable number of sample frames. All four outputs then leave time-aligned for the beamforming/summing stage.
- Implemented as a shared circular sample buffer: one write pointer and four per-channel read offsets.

Parameters:
- DATA_W, 12, bits per channel sample
- DEPTH, 64, buffer entries per channel (power of 2); maximum delay is DEPTH-1 frames
- ADDR_W, 6, log2(DEPTH)

Ports:
- clk  in  1  system clock (≥ 250 kHz; frames arrive as strobes)
- rst_n  in  1  asynchronous active-low reset
- sample_valid  in  1  one-cycle strobe; data_in1..4 valid this cycle
- data_in1..data_in4  in  DATA_W each  channel samples, unsigned
- delay1..delay4  in  ADDR_W each  requested delay per channel, in frames
- delay_load  in  1  one-cycle pulse; latch delay1..4
- data_out1..data_out4  out  DATA_W each  aligned samples
- out_valid  out  1  one-cycle strobe; outputs updated
- primed  out  1  high in RUN state

Behaviour:
- Reset (async, rst_n=0): wr_ptr=0, fill_cnt=0, latched delays=0, state=FILL, data_out*=0, out_valid=0, primed=0. Buffer contents are don't-care; no read of unwritten data may reach an output.
- Frame write: on sample_valid, write all 4 samples at wr_ptr, then wr_ptr <= wr_ptr+1 (mod DEPTH). fill_cnt increments and saturates at DEPTH-1.
- Read:
  - Channel k output = sample written d_k frames before the current frame.
  - d_k=0 bypasses the buffer and uses the current data_ink.
  - d_k=DEPTH-1 reads address wr_ptr+1, which is not yet overwritten.
  - Read-before-write or bypass is required; a same-cycle write must never corrupt a read.
- Latency: data_out*/out_valid registered exactly 1 clk after sample_valid. Outputs hold between frames.
- max_d = max(d_1..d_4), computed from latched delays.
- State machine:
  - FILL: out_valid suppressed and data_out* hold. Move to RUN on a frame where fill_cnt (before increment) ≥ max_d; that frame produces the first out_valid.
  - RUN: every sample_valid gives an out_valid. primed=1.
  - From RUN on delay_load: if new max_d > fill_cnt, go to FILL; otherwise stay in RUN.
- delay_load rules:
  - New delays take effect from the next sample_valid.
  - If delay_load and sample_valid coincide, the current frame uses the old delays; the new delays apply from the following frame.
  - Buffer contents and wr_ptr are not cleared.
- Back-to-back sample_valid on consecutive clocks is legal; a full frame is processed each cycle.
- Wrap-around: wr_ptr rolls DEPTH-1 → 0 seamlessly. Read address = wr_ptr − d_k mod DEPTH.
- sample_valid while rst_n=0 is ignored. Reset mid-stream returns to FILL, and the first post-reset out_valid obeys the fill rule.

Optional Feature:
- Macro: LNVD_ALIGN_ZERO_FILL_EN
- Defined:
  - out_valid is asserted on every frame, including in FILL.
  - Any channel with d_k > fill_cnt outputs 0; the others output normally.
  - primed still reflects the RUN state.
- Undefined: out_valid is suppressed in FILL, as above.

Test Plan:
- Reset, delays all 0, frames ch1=0x001,0x002,0x003 → out_valid 1 clk after each strobe; data_out1 = 0x001,0x002,0x003; primed=1 after first frame.
- delay1=3, delay2..4=0, ramp input 0x010,0x011,… → no out_valid for frames 0–2. Frame 3 gives data_out1=0x010 and data_out2=0x013; constant skew thereafter.
- Delay 63 on ch4, run 200 frames of ramp → data_out4 = input−63 across wr_ptr wrap points; no glitch at 63→0.
- In RUN with fill_cnt=10, delay_load raising delay2 to 40 coincident with sample_valid → that frame uses old delay; primed drops. out_valid resumes when fill_cnt reaches 40, with data_out2 = input−40.
- Deassert rst_n asynchronously mid-frame-stream → all outputs 0 immediately; FILL re-entered; delays reset to 0, so first frame after release yields out_valid.
- With LNVD_ALIGN_ZERO_FILL_EN, delay3=5 → out_valid from frame 0; data_out3=0 for frames 0–4, then input−5.
